// File: rtl/iob_plic_wrapper.sv
// iob_plic_wrapper: RISC-V PLIC subset (priority, enable, threshold, claim/complete) on an IOb slave port.
// Define PLIC_EDGE_TRIGGER_EN for a rising-edge gateway; the default gateway is level-triggered.
module iob_plic_wrapper #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int N_SOURCES = 8,
    parameter int N_TARGETS = 2
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   iob_avalid,
    input  logic [ADDR_W-1:0]      iob_addr,
    input  logic [DATA_W-1:0]      iob_wdata,
    input  logic [DATA_W/8-1:0]    iob_wstrb,
    output logic                   iob_rvalid,
    output logic [DATA_W-1:0]      iob_rdata,
    output logic                   iob_ready,
    input  logic [N_SOURCES-1:0]   srip,
    output logic [N_TARGETS-1:0]   meip
);

    localparam int ID_W = $clog2(N_SOURCES + 1);

    logic [ADDR_W-1:0]    addr_s;
    logic                 wr_s;
    logic                 rd_s;
    logic                 unused_s;
    logic [DATA_W-1:0]    wmask_s;
    logic [DATA_W-1:0]    wval_s;
    logic [DATA_W-1:0]    rd_data_s;
    logic                 pend_hit_s;
    logic [N_SOURCES:1]   prio_hit_s;
    logic [N_TARGETS-1:0] en_hit_s;
    logic [N_TARGETS-1:0] th_hit_s;
    logic [N_TARGETS-1:0] cl_hit_s;

    logic [2:0]           prio_r [1:N_SOURCES];
    logic [N_SOURCES:1]   enable_r [N_TARGETS];
    logic [2:0]           thresh_r [N_TARGETS];
    logic [N_SOURCES:1]   pending_r;
    logic [N_SOURCES:1]   in_service_r;
    logic [N_SOURCES:1]   pending_nxt_s;
    logic [N_SOURCES:1]   in_service_nxt_s;
    logic [N_SOURCES:1]   claim_s;
    logic [N_SOURCES:1]   complete_s;
    logic [ID_W-1:0]      best_id_s [N_TARGETS];
    logic [2:0]           best_prio_s;
    logic [N_TARGETS-1:0] meip_r;
    logic                 rvalid_r;
    logic [DATA_W-1:0]    rdata_r;
`ifdef PLIC_EDGE_TRIGGER_EN
    logic [N_SOURCES:1]   srip_q_r;
`endif

    assign addr_s    = {iob_addr[ADDR_W-1:2], 2'b00};
    assign unused_s  = ^iob_addr[1:0];
    assign wr_s      = iob_avalid & (|iob_wstrb);
    assign rd_s      = iob_avalid & ~(|iob_wstrb);

    assign iob_ready  = 1'b1;
    assign iob_rvalid = rvalid_r;
    assign iob_rdata  = rdata_r;
    assign meip       = meip_r;

    // Address decode into one-hot register hits.
    always_comb begin
        pend_hit_s = (addr_s == ADDR_W'(32'h100));
        prio_hit_s = {N_SOURCES{1'b0}};
        en_hit_s   = {N_TARGETS{1'b0}};
        th_hit_s   = {N_TARGETS{1'b0}};
        cl_hit_s   = {N_TARGETS{1'b0}};
        for (int s = 1; s <= N_SOURCES; s++) begin
            prio_hit_s[s] = (addr_s == ADDR_W'(32'd4 * 32'(s)));
        end
        for (int t = 0; t < N_TARGETS; t++) begin
            en_hit_s[t] = (addr_s == ADDR_W'(32'h200 + 32'd4 * 32'(t)));
            th_hit_s[t] = (addr_s == ADDR_W'(32'h300 + 32'd8 * 32'(t)));
            cl_hit_s[t] = (addr_s == ADDR_W'(32'h304 + 32'd8 * 32'(t)));
        end
    end

    // Byte-strobe expansion; unstrobed bytes of the write value read as zero.
    always_comb begin
        wmask_s = {DATA_W{1'b0}};
        for (int b = 0; b < DATA_W / 8; b++) begin
            wmask_s[8*b +: 8] = {8{iob_wstrb[b]}};
        end
        wval_s = iob_wdata & wmask_s;
    end

    // Per-target arbitration: strict '>' against the running best gives lowest-ID tie-break
    // and makes priority 0 (or anything not above threshold) never qualify.
    always_comb begin
        best_prio_s = 3'd0;
        for (int t = 0; t < N_TARGETS; t++) begin
            best_prio_s  = thresh_r[t];
            best_id_s[t] = {ID_W{1'b0}};
            for (int s = 1; s <= N_SOURCES; s++) begin
                if (pending_r[s] && enable_r[t][s] && (prio_r[s] > best_prio_s)) begin
                    best_prio_s  = prio_r[s];
                    best_id_s[t] = ID_W'(s);
                end else begin
                    best_prio_s  = best_prio_s;
                end
            end
        end
    end

    // Claim and complete strobes per source.
    always_comb begin
        claim_s    = {N_SOURCES{1'b0}};
        complete_s = {N_SOURCES{1'b0}};
        for (int s = 1; s <= N_SOURCES; s++) begin
            for (int t = 0; t < N_TARGETS; t++) begin
                claim_s[s]    = claim_s[s] | (rd_s & cl_hit_s[t] & (best_id_s[t] == ID_W'(s)));
                complete_s[s] = complete_s[s] |
                                (wr_s & cl_hit_s[t] & enable_r[t][s] & (wval_s == DATA_W'(s)));
            end
        end
    end

    // Gateway next state.
    always_comb begin
`ifdef PLIC_EDGE_TRIGGER_EN
        pending_nxt_s = (srip & ~srip_q_r) | (pending_r & ~claim_s);
`else
        pending_nxt_s = (pending_r | (srip & ~in_service_r)) & ~claim_s;
`endif
        in_service_nxt_s = claim_s | (in_service_r & ~complete_s);
    end

    // Read data mux; unmapped addresses fall through as zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        rd_data_s = rd_data_s | ({DATA_W{pend_hit_s}} & DATA_W'({pending_r, 1'b0}));
        for (int s = 1; s <= N_SOURCES; s++) begin
            rd_data_s = rd_data_s | ({DATA_W{prio_hit_s[s]}} & DATA_W'(prio_r[s]));
        end
        for (int t = 0; t < N_TARGETS; t++) begin
            rd_data_s = rd_data_s | ({DATA_W{en_hit_s[t]}} & DATA_W'({enable_r[t], 1'b0}));
            rd_data_s = rd_data_s | ({DATA_W{th_hit_s[t]}} & DATA_W'(thresh_r[t]));
            rd_data_s = rd_data_s | ({DATA_W{cl_hit_s[t]}} & DATA_W'(best_id_s[t]));
        end
    end

    // Registered read response, one cycle after the request.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= rd_s;
            rdata_r  <= rd_s ? rd_data_s : rdata_r;
        end
    end

    // Configuration registers: priorities, enables, thresholds.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int s = 1; s <= N_SOURCES; s++) prio_r[s] <= 3'd0;
            for (int t = 0; t < N_TARGETS; t++) begin
                enable_r[t] <= {N_SOURCES{1'b0}};
                thresh_r[t] <= 3'd0;
            end
        end else begin
            for (int s = 1; s <= N_SOURCES; s++) begin
                if (wr_s && prio_hit_s[s] && iob_wstrb[0]) prio_r[s] <= iob_wdata[2:0];
            end
            for (int t = 0; t < N_TARGETS; t++) begin
                if (wr_s && en_hit_s[t]) begin
                    enable_r[t] <= (enable_r[t] & ~wmask_s[N_SOURCES:1]) |
                                   (iob_wdata[N_SOURCES:1] & wmask_s[N_SOURCES:1]);
                end
                if (wr_s && th_hit_s[t] && iob_wstrb[0]) thresh_r[t] <= iob_wdata[2:0];
            end
        end
    end

    // Gateway state: pending and in-service bits.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            pending_r    <= {N_SOURCES{1'b0}};
            in_service_r <= {N_SOURCES{1'b0}};
`ifdef PLIC_EDGE_TRIGGER_EN
            srip_q_r     <= {N_SOURCES{1'b0}};
`endif
        end else begin
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
`ifdef PLIC_EDGE_TRIGGER_EN
            srip_q_r     <= srip;
`endif
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            meip_r <= {N_TARGETS{1'b0}};
        end else begin
            for (int t = 0; t < N_TARGETS; t++) meip_r[t] <= |best_id_s[t];
        end
    end

endmodule

// File: tb/tb_iob_plic_wrapper.sv
// Self-checking bench for iob_plic_wrapper: register table plus hand-written interrupt sequences.
module tb_iob_plic_wrapper;

    logic        clk_i;
    logic        arst_i;
    logic        iob_avalid;
    logic [15:0] iob_addr;
    logic [31:0] iob_wdata;
    logic [3:0]  iob_wstrb;
    logic        iob_rvalid;
    logic [31:0] iob_rdata;
    logic        iob_ready;
    logic [7:0]  srip;
    logic [1:0]  meip;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [22];

    iob_plic_wrapper #(.ADDR_W(16), .DATA_W(32), .N_SOURCES(8), .N_TARGETS(2)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
        .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata), .iob_ready(iob_ready),
        .srip(srip), .meip(meip)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk_i);
        iob_avalid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = s;
        @(negedge clk_i);
        iob_avalid = 1'b0; iob_wstrb = 4'h0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp);
        @(negedge clk_i);
        iob_avalid = 1'b1; iob_addr = a; iob_wstrb = 4'h0;
        exp_q.push_back({a, exp});
        @(negedge clk_i);
        iob_avalid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Scoreboard monitor: a read accepted at an edge must show rvalid and its data right after it.
    always @(posedge clk_i) begin
        #1;
        if (arst_i) begin
            if (iob_avalid && iob_wstrb == 4'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: read at 0x%0h with no expectation", iob_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (iob_rvalid !== 1'b1 || iob_rdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL rd@0x%0h: got rvalid=%0b data=0x%0h, expected rvalid=1 data=0x%0h",
                                 mon_e.addr, iob_rvalid, iob_rdata, mon_e.data);
                    end
                end
            end else if (iob_rvalid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_spurious: got rvalid=%0b, expected 0", iob_rvalid);
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0};
        vecs[1]  = '{1'b0, 16'h0100, 32'h0,        4'h0, 32'h0};
        vecs[2]  = '{1'b0, 16'h0200, 32'h0,        4'h0, 32'h0};
        vecs[3]  = '{1'b0, 16'h0304, 32'h0,        4'h0, 32'h0};
        vecs[4]  = '{1'b0, 16'h0308, 32'h0,        4'h0, 32'h0};
        vecs[5]  = '{1'b1, 16'h0018, 32'hFFFFFF07, 4'h1, 32'h0};
        vecs[6]  = '{1'b0, 16'h0018, 32'h0,        4'h0, 32'h7};
        vecs[7]  = '{1'b1, 16'h0018, 32'h00000000, 4'h2, 32'h0};
        vecs[8]  = '{1'b0, 16'h0018, 32'h0,        4'h0, 32'h7};
        vecs[9]  = '{1'b0, 16'h03FC, 32'h0,        4'h0, 32'h0};
        vecs[10] = '{1'b1, 16'h03FC, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[11] = '{1'b0, 16'h03FC, 32'h0,        4'h0, 32'h0};
        vecs[12] = '{1'b1, 16'h0000, 32'h00000007, 4'h1, 32'h0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0};
        vecs[14] = '{1'b1, 16'h0200, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[15] = '{1'b0, 16'h0200, 32'h0,        4'h0, 32'h1FE};
        vecs[16] = '{1'b1, 16'h0200, 32'h00000000, 4'hF, 32'h0};
        vecs[17] = '{1'b1, 16'h0300, 32'h000000FF, 4'h1, 32'h0};
        vecs[18] = '{1'b0, 16'h0300, 32'h0,        4'h0, 32'h7};
        vecs[19] = '{1'b1, 16'h0300, 32'h00000000, 4'h1, 32'h0};
        vecs[20] = '{1'b1, 16'h0208, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[21] = '{1'b0, 16'h0208, 32'h0,        4'h0, 32'h0};

        arst_i = 1'b0; iob_avalid = 1'b0; iob_addr = 16'h0; iob_wdata = 32'h0;
        iob_wstrb = 4'h0; srip = 8'h00;
        #100;
        chk("rst_meip", 32'(meip), 32'h0);
        chk("rst_rvalid", 32'(iob_rvalid), 32'h0);
        chk("rst_rdata", iob_rdata, 32'h0);
        arst_i = 1'b1;
        chk("ready_const", 32'(iob_ready), 32'h1);

        // Register map, reset values, strobes and unmapped addresses.
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            else            bus_rd(vecs[i].addr, vecs[i].exp);
        end

        // Basic route: source 3 to target 0.
        bus_wr(16'h000C, 32'd5, 4'h1);
        bus_wr(16'h0200, 32'h08, 4'hF);
        bus_wr(16'h0300, 32'd2, 4'h1);
        srip = 8'h04;
        wait_cycles(1);
        chk("route_meip_edge1", 32'(meip), 32'h0);
        wait_cycles(1);
        chk("route_meip_edge2", 32'(meip), 32'h1);
        bus_rd(16'h0304, 32'd3);
        chk("claim_meip_hold", 32'(meip), 32'h1);
        wait_cycles(1);
        chk("claim_meip_drop", 32'(meip), 32'h0);

        // Complete with srip held high re-pends; then drop srip and retire.
        bus_wr(16'h0304, 32'd3, 4'h1);
        bus_rd(16'h0100, 32'h08);
        chk("relevel_meip", 32'(meip), 32'h1);
        srip = 8'h00;
        bus_rd(16'h0304, 32'd3);
        bus_wr(16'h0304, 32'd3, 4'h1);
        wait_cycles(3);
        chk("retire_meip", 32'(meip), 32'h0);
        bus_rd(16'h0100, 32'h0);

        // Priority order and lowest-ID tie-break on target 1.
        bus_wr(16'h0004, 32'd2, 4'h1);
        bus_wr(16'h0008, 32'd6, 4'h1);
        bus_wr(16'h0010, 32'd6, 4'h1);
        bus_wr(16'h0204, 32'h16, 4'hF);
        bus_wr(16'h0308, 32'd0, 4'h1);
        srip = 8'h0B;
        wait_cycles(2);
        chk("tie_meip", 32'(meip), 32'h2);
        bus_rd(16'h030C, 32'd2);
        bus_rd(16'h030C, 32'd4);
        bus_rd(16'h030C, 32'd1);
        bus_rd(16'h030C, 32'd0);
        chk("tie_meip_clear", 32'(meip), 32'h0);
        srip = 8'h00;
        bus_wr(16'h030C, 32'd2, 4'h1);
        bus_wr(16'h030C, 32'd4, 4'h1);
        bus_wr(16'h030C, 32'd1, 4'h1);
        bus_rd(16'h0100, 32'h0);

        // Threshold masks a source at equal priority.
        bus_wr(16'h0014, 32'd3, 4'h1);
        bus_wr(16'h0300, 32'd3, 4'h1);
        bus_wr(16'h0200, 32'h28, 4'hF);
        srip = 8'h10;
        wait_cycles(3);
        chk("thr_mask_meip", 32'(meip), 32'h0);
        bus_rd(16'h0304, 32'd0);
        bus_wr(16'h0300, 32'd2, 4'h1);
        wait_cycles(1);
        chk("thr_lower_meip", 32'(meip), 32'h1);
        bus_rd(16'h0304, 32'd5);

        // Complete from a target that lacks the enable is ignored.
        bus_wr(16'h030C, 32'd5, 4'h1);
        bus_rd(16'h0100, 32'h0);
        bus_wr(16'h0304, 32'd5, 4'h1);
        bus_rd(16'h0100, 32'h20);

        // Reset mid-operation drops an outstanding rvalid and clears state.
        @(negedge clk_i);
        iob_avalid = 1'b1; iob_addr = 16'h0014; iob_wstrb = 4'h0;
        exp_q.push_back({16'h0014, 32'd3});
        @(posedge clk_i);
        #3;
        arst_i = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(iob_rvalid), 32'h0);
        chk("midrst_meip", 32'(meip), 32'h0);
        @(negedge clk_i);
        iob_avalid = 1'b0; srip = 8'h00;
        wait_cycles(2);
        arst_i = 1'b1;
        bus_rd(16'h0014, 32'h0);
        bus_rd(16'h0100, 32'h0);
        bus_rd(16'h0200, 32'h0);
        bus_rd(16'h0300, 32'h0);
        wait_cycles(2);
        chk("postrst_meip", 32'(meip), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_plic_wrapper.md
Name: iob_plic_wrapper

Overview:
- Platform-Level Interrupt Controller (RISC-V PLIC subset) behind an IOb native slave port.
- Collects N_SOURCES level interrupt lines (srip) and drives one machine external interrupt line per hart target (meip).
- Provides per-source priority, per-target enable and threshold, and a claim/complete protocol.
- Sits between the peripheral interrupt lines and the CPU cores' meip inputs.

Parameters:
- ADDR_W, 16: IOb address width (byte address).
- DATA_W, 32: IOb data width; the register map assumes 32.
- N_SOURCES, 8: number of interrupt sources, 1..31. srip[i] is source ID i+1; ID 0 means "none".
- N_TARGETS, 2: number of targets (harts), 1..8.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- arst_i  in  1  asynchronous reset, active-low.
- iob_avalid  in  1  request valid.
- iob_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- iob_wdata  in  DATA_W  write data.
- iob_wstrb  in  DATA_W/8  byte strobes; zero means read.
- iob_rvalid  out  1  read data valid.
- iob_rdata  out  DATA_W  read data.
- iob_ready  out  1  request accepted.
- srip  in  N_SOURCES  source interrupt request lines, level, active-high.
- meip  out  N_TARGETS  external interrupt to each target.

Behaviour:
- Reset values: all priorities, enables, thresholds, pending and in-service bits are 0; meip=0; iob_rvalid=0; iob_rdata=0.
- iob_ready is constant 1, so every avalid cycle is one accepted request.
- Reads: iob_rvalid pulses exactly 1 cycle after the request, with registered iob_rdata.
- Writes: applied at the request edge; no rvalid; byte strobes honoured per byte.
- Register map, 32-bit words:
  - 0x000+4*s: priority of source s (s=1..N_SOURCES), bits [2:0] RW.
  - 0x100: pending, bit s = source s, read-only.
  - 0x200+4*t: enable of target t, bit s; bit 0 reads 0.
  - 0x300+8*t: threshold of target t, bits [2:0] RW.
  - 0x304+8*t: claim on read, complete on write.
  - Unmapped addresses: read 0; writes ignored.
- Gateway (level mode):
  - pending[s] is set on the clock edge where srip is high and in-service[s]=0.
  - Claiming a source clears pending[s] and sets in-service[s].
  - Writing complete with ID s, where s is enabled for that target, clears in-service[s]. Other IDs are ignored.
- Claim read returns the ID with the highest priority among sources that are pending, enabled for the target, and above the target's threshold. Ties go to the lowest ID. Returns 0 when no source qualifies; a 0 claim changes no state.
- Same-cycle claims from two targets of the same ID cannot occur because the bus is single-port.
- Priority 0 never interrupts.
- meip[t] is registered and is 1 iff any source is pending, enabled for t, and has priority > threshold[t].
- Latency: srip rise -> pending set at edge 1 -> meip high at edge 2.
- Claim clears meip at the following edge unless another qualifying source exists.
- srip held high after complete re-pends the source on the next edge.
- Reset mid-operation clears everything asynchronously; an outstanding rvalid is dropped.

Optional Feature:
- Macro PLIC_EDGE_TRIGGER_EN.
- Defined: the gateway latches pending on a 0->1 edge of srip (registered previous value), independent of in-service. Edges that arrive while pending is already set are merged into that pending bit.
- Undefined: level-triggered gateway as described above.

Test Plan:
- Reset: hold arst_i=0 for 100 ns, release. Required: meip=0; reads of 0x004, 0x100, 0x200 and 0x304 return 0.
- Basic route: prio[3]=5 (0x00C), enable t0=0x08, threshold t0=2, srip[2]=1. Required: meip[0]=1 two cycles later, meip[1]=0; claim at 0x304 returns 3; meip[0] drops.
- Complete/relevel: keep srip[2]=1, write 3 to 0x304. Required: pending bit 3 sets again and meip[0] reasserts. Drop srip, claim, complete: meip stays 0.
- Priority and tie: prio[1]=2, prio[2]=6, prio[4]=6, all enabled for t1, threshold 0, srip=0x0B. Required: claim at 0x30C returns 2, then 4, then 1, then 0.
- Threshold mask: prio[5]=3, threshold t0=3, srip[4]=1. Required: meip[0]=0 and claim returns 0. Lower threshold to 2: meip[0]=1.
- Bus: write with wstrb=0x1 to prio[6] using data 0xFFFFFF07. Required: reads back 7. Read 0x3FC: returns 0 with rvalid one cycle later.
